seg_shift_out: RTL

SEG_SHIFT_OUT -- requirements
Module: seg_shift_out

---
 rtl/seg_shift_out.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg_shift_out.sv
// Serialises a 64-bit segment pattern MSB first into an external shift-register chain, then strobes SEG_PEN.
// Define SEG_SHIFT_REFRESH_EN to retransmit SEG_TXT automatically REFRESH_GAP idle cycles after each frame.
module seg_shift_out #(
   parameter int unsigned DIV         = 2,
   parameter int unsigned REFRESH_GAP = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] SEG_TXT,
   output logic        busy,
   output logic        done,
   output logic        seg_clk,
   output logic        seg_sout,
   output logic        SEG_PEN,
   output logic        seg_clrn
);

   if (DIV < 1 || DIV > 255 || REFRESH_GAP < 1) begin : g_bad_param
      $error("seg_shift_out: DIV must be 1..255 and REFRESH_GAP at least 1");
   end

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   state_t      state_q, state_d;
   logic [63:0] shreg_q, shreg_d;
   logic [5:0]  bit_q, bit_d;
   logic [7:0]  div_q, div_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        sclk_q, sclk_d;
   logic        sout_q, sout_d;
   logic        pen_q, pen_d;
   logic        clrn_q, clrn_d;
   logic        div_end;
   logic        go;
   logic        auto_go;

`ifdef SEG_SHIFT_REFRESH_EN
   localparam int unsigned GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REFRESH_GAP - 1);

   logic [GAP_W-1:0] gap_q, gap_d;
   logic             arm_q, arm_d;

   // Auto refresh only runs once a frame has completed since the last reset.
   assign auto_go = (state_q == IDLE) && arm_q && (gap_q == GAP_LAST);
`else
   assign auto_go = 1'b0;
`endif

   assign div_end = (div_q == DIV_LAST);
   assign go      = start | auto_go;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      div_d   = div_q;
`ifdef SEG_SHIFT_REFRESH_EN
      gap_d   = gap_q;
      arm_d   = arm_q;
`endif
      case (state_q)
         IDLE: begin
            if (go) begin
               shreg_d = SEG_TXT;
               bit_d   = '0;
               div_d   = '0;
               state_d = SHIFT_LO;
            end
`ifdef SEG_SHIFT_REFRESH_EN
            if (go)
               gap_d = '0;
            else if (arm_q)
               gap_d = gap_q + 1'b1;
`endif
         end
         SHIFT_LO: begin
            if (div_end) begin
               div_d   = '0;
               state_d = SHIFT_HI;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         SHIFT_HI: begin
            if (div_end) begin
               div_d   = '0;
               shreg_d = {shreg_q[62:0], 1'b0};
               bit_d   = bit_q + 6'd1;
               state_d = (bit_q == 6'd63) ? LATCH : SHIFT_LO;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         LATCH: begin
            if (div_end) begin
               div_d   = '0;
               state_d = DONE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef SEG_SHIFT_REFRESH_EN
            arm_d   = 1'b1;
            gap_d   = '0;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      sclk_d = (state_d == SHIFT_HI);
      pen_d  = (state_d == LATCH);
      sout_d = (state_d == SHIFT_LO) ? shreg_d[63] : sout_q;
      clrn_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sout_q  <= 1'b0;
         pen_q   <= 1'b0;
         clrn_q  <= 1'b0;
`ifdef SEG_SHIFT_REFRESH_EN
         gap_q   <= '0;
         arm_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         sout_q  <= sout_d;
         pen_q   <= pen_d;
         clrn_q  <= clrn_d;
`ifdef SEG_SHIFT_REFRESH_EN
         gap_q   <= gap_d;
         arm_q   <= arm_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign seg_clk  = sclk_q;
   assign seg_sout = sout_q;
   assign SEG_PEN  = pen_q;
   assign seg_clrn = clrn_q;

endmodule
